ram_sp_rr_arbiter_ctrl: RTL and testbench



---
 rtl/ram_sp_rr_arbiter_ctrl_if.sv | 52 +++++
 rtl/ram_sp_rr_arbiter_ctrl.sv | 109 ++++++++++
 tb/tb_ram_sp_rr_arbiter_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_rr_arbiter_ctrl_if.sv
// Requester, response and RAM-side signals of the shared single-port RAM controller.
// master = controller view, slave = clients plus RAM view.
interface ram_sp_rr_arbiter_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  // Handshake: rqN_req (with we/addr/wdata) is held until rqN_gnt is seen high
  // in the same cycle; the access is taken on that clock edge, and rqN_rvalid
  // marks rdata as the response exactly one cycle later. Dropping req before
  // gnt withdraws the request.
  logic              rq0_req;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_gnt;
  logic              rq0_rvalid;

  logic              rq1_req;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_gnt;
  logic              rq1_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              init_busy;

  logic              mem_en;
  logic              mem_we;
  logic              mem_rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_dout,
    output rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid,
    output rdata, init_busy,
    output mem_en, mem_we, mem_rst, mem_addr, mem_di
  );

  modport slave (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_dout,
    input  rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid,
    input  rdata, init_busy,
    input  mem_en, mem_we, mem_rst, mem_addr, mem_di
  );
endinterface

// File: rtl/ram_sp_rr_arbiter_ctrl.sv
// Two-requester round-robin controller for a single-port write-first RAM.
// Zero-fills every address after reset, then grants one access per cycle.
module ram_sp_rr_arbiter_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic clk,
  input  logic rst,
  ram_sp_rr_arbiter_ctrl_if.master bus,
  output logic dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              rv0_q, rv1_q;
  logic              gnt0, gnt1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_gnt_d   = last_gnt_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_rst  = 1'b0;
    bus.mem_addr = '0;
    bus.mem_di   = '0;

    if (rst) begin
      // Enabled output reset clears the RAM read register during reset.
      state_d     = ST_INIT;
      cnt_d       = '0;
      last_gnt_d  = 1'b1;
      bus.mem_en  = 1'b1;
      bus.mem_rst = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          bus.mem_en   = 1'b1;
          bus.mem_we   = 1'b1;
          bus.mem_addr = cnt_q;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          // On contention the requester that did not win last time goes first.
          if (bus.rq0_req && (!bus.rq1_req || last_gnt_q)) begin
            gnt0 = 1'b1;
          end else if (bus.rq1_req) begin
            gnt1 = 1'b1;
          end
          if (gnt0) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.rq0_we;
            bus.mem_addr = bus.rq0_addr;
            bus.mem_di   = bus.rq0_wdata;
            last_gnt_d   = 1'b0;
          end else if (gnt1) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.rq1_we;
            bus.mem_addr = bus.rq1_addr;
            bus.mem_di   = bus.rq1_wdata;
            last_gnt_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    last_gnt_q <= last_gnt_d;
    if (rst) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= gnt0;
      rv1_q <= gnt1;
    end
  end

  // A response already in flight is suppressed when reset arrives in its cycle.
  assign bus.rq0_gnt    = gnt0;
  assign bus.rq1_gnt    = gnt1;
  assign bus.rq0_rvalid = rv0_q & ~rst;
  assign bus.rq1_rvalid = rv1_q & ~rst;
  assign bus.rdata      = bus.mem_dout;
  assign bus.init_busy  = (state_q == ST_INIT) & ~rst;
  assign dbg_state      = (state_q == ST_RUN);

endmodule

// File: tb/tb_ram_sp_rr_arbiter_ctrl.sv
// Directed bench for ram_sp_rr_arbiter_ctrl with a behavioural write-first RAM
// and a response scoreboard fed by the drivers and drained by a monitor.
module tb_ram_sp_rr_arbiter_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int W      = DATA_W + 1;

  logic clk;
  logic rst;
  logic dbg_state;

  ram_sp_rr_arbiter_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_sp_rr_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ram_filled = 1'b0;

  always @(posedge clk) begin
    if (!ram_filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hBEEF ^ 16'(i);
      ram_filled <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_rst) begin
        bus.mem_dout <= '0;
      end else if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_di;
        bus.mem_dout      <= bus.mem_di;
      end else begin
        bus.mem_dout <= mem[bus.mem_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.rq0_rvalid === 1'b1 && bus.rq1_rvalid === 1'b1) begin
      chk("rvalid_onehot", 32'd1, 32'd0);
    end else if (bus.rq0_rvalid === 1'b1 || bus.rq1_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {31'd0, bus.rq1_rvalid}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", {31'd0, bus.rq1_rvalid}, {31'd0, e[DATA_W]});
        chk("resp_data", {16'd0, bus.rdata}, {16'd0, e[DATA_W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Checks every INIT cycle; optionally withdraws rq0_req at iteration drop_i.
  task automatic sweep(input int n, input int drop_i);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("init_busy", {31'd0, bus.init_busy}, 32'd1);
      chk("init_we", {31'd0, bus.mem_we}, 32'd1);
      chk("init_addr", {23'd0, bus.mem_addr}, 32'(i));
      chk("init_di", {16'd0, bus.mem_di}, 32'd0);
      chk("init_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd0);
      if (i == 0) chk("dout_after_rst", {16'd0, bus.mem_dout}, 32'd0);
      if (i == drop_i) bus.rq0_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the response cycle.
  task automatic access(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_data,
                        input int exp_wait);
    int   waited;
    logic g;
    waited = 0;
    if (port == 0) begin
      bus.rq0_req = 1'b1; bus.rq0_we = we; bus.rq0_addr = addr; bus.rq0_wdata = wdata;
    end else begin
      bus.rq1_req = 1'b1; bus.rq1_we = we; bus.rq1_addr = addr; bus.rq1_wdata = wdata;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = (port == 0) ? bus.rq0_gnt : bus.rq1_gnt;
      if (g === 1'b1) break;
      waited++;
      @(posedge clk); #1;
    end
    chk("gnt_wait", 32'(waited), 32'(exp_wait));
    if (waited < 4) exp_q.push_back({(port != 0), exp_data});
    @(posedge clk); #1;
    if (port == 0) bus.rq0_req = 1'b0;
    else bus.rq1_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic pat [4];

  initial begin
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.rq0_req = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 9'h1FF; bus.rq1_wdata = '0;
    rst = 1'b1;

    // Reset with rq1 already requesting: nothing may be granted.
    @(negedge clk);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("rst_mem_rst", {31'd0, bus.mem_rst}, 32'd1);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    sweep(DEPTH, -1);

    // First RUN cycle: pending rq1 read of never-written 0x1FF.
    @(negedge clk);
    chk("run_init_busy", {31'd0, bus.init_busy}, 32'd0);
    chk("first_run_gnt1", {31'd0, bus.rq1_gnt}, 32'd1);
    chk("first_run_addr", {23'd0, bus.mem_addr}, 32'h1FF);
    chk("first_run_we", {31'd0, bus.mem_we}, 32'd0);
    exp_q.push_back({1'b1, 16'h0000});
    @(posedge clk); #1;
    bus.rq1_req = 1'b0;

    // Write echo then read-back from the other requester.
    access(0, 1'b1, 9'h005, 16'hA5A5, 16'hA5A5, 0);
    access(1, 1'b0, 9'h005, 16'h0000, 16'hA5A5, 0);

    // Reset in the cycle after a grant: response must be dropped.
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 9'h005;
    @(negedge clk);
    chk("pre_rst_gnt0", {31'd0, bus.rq0_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.rq0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_rvalid", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset at sweep counter 100 restarts from address 0 for a full sweep.
    sweep(100, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_init_rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("mid_init_rst_busy", {31'd0, bus.init_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rq0_req = 1'b1; bus.rq0_addr = 9'h020;
    sweep(DEPTH, 300);
    @(negedge clk);
    chk("withdrawn_no_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd0);
    chk("idle_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("idle_busy", {31'd0, bus.init_busy}, 32'd0);
    @(posedge clk); #1;

    // Both hold reads: grants alternate starting with requester 0.
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 9'h010;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 9'h011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt0", {31'd0, bus.rq0_gnt}, {31'd0, ~pat[k]});
      chk("rr_gnt1", {31'd0, bus.rq1_gnt}, {31'd0, pat[k]});
      chk("rr_addr", {23'd0, bus.mem_addr}, pat[k] ? 32'h011 : 32'h010);
      exp_q.push_back({pat[k], 16'h0000});
      @(posedge clk); #1;
    end
    bus.rq0_req = 1'b0; bus.rq1_req = 1'b0;

    // Simultaneous writes: last winner was 1, so 0 goes first, 1 the next cycle.
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 9'h011; bus.rq0_wdata = 16'h5678;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 9'h010; bus.rq1_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_first_gnt0", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd1);
    exp_q.push_back({1'b0, 16'h5678});
    @(posedge clk); #1;
    bus.rq0_req = 1'b0;
    @(negedge clk);
    chk("wr_loser_gnt1", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd2);
    exp_q.push_back({1'b1, 16'h1234});
    @(posedge clk); #1;
    bus.rq1_req = 1'b0;

    access(0, 1'b0, 9'h010, 16'h0000, 16'h1234, 0);
    access(1, 1'b0, 9'h011, 16'h0000, 16'h5678, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
